// File: rtl/seg7_pkg.sv
// Shared font, rotation and digit-select helpers for the multiplexed 7-segment driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg7_font(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // 180-degree rotation swaps a<->d, b<->e, c<->f and leaves g alone.
  function automatic logic [6:0] seg7_flip(input logic [6:0] pat);
    return {pat[6], pat[2], pat[1], pat[0], pat[5], pat[4], pat[3]};
  endfunction

  function automatic logic [7:0] seg7_onecold(input logic [2:0] idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle, MSB first.
// Any carry out of the top BCD nibble marks the value as too large for DIGITS digits.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  import seg7_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic                ovf_q, ovf_d;

  assign done = busy_q && (cnt_q == CW'(WIDTH));

  always_comb begin
    adj    = bcd_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = '0;
        sh_d   = bin;
        bcd_d  = '0;
        ovf_d  = 1'b0;
      end
    end else if (done) begin
      busy_d = 1'b0;
    end else begin
      bcd_d = {adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
      ovf_d = ovf_q | adj[4*DIGITS-1];
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_scan_bcd.sv
// Multiplexed 7-segment driver: loads a binary value through the BCD converter, then scans
// the digits with blanking, rotation and overflow dashes; an and seg are registered together.
module seg7_scan_bcd #(
  parameter int DIGITS   = 8,
  parameter int WIDTH    = 16,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  val,
  input  logic              val_load,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] flip_mask,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  import seg7_pkg::*;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                conv_done, conv_ovf;
  logic [4*DIGITS-1:0] conv_bcd;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (val_load),
    .bin   (val),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d, lz;
  logic [3:0]          nib;
  logic [7:0]          an_all;
  logic                zero_above, tc;

  assign tc     = (div_q == DW'(SCAN_DIV - 1));
  assign an_all = seg7_onecold(3'(idx_q));

  always_comb begin
    disp_d     = conv_done ? conv_bcd : disp_q;
    ovf_d      = conv_done ? conv_ovf : ovf_q;
    div_d      = tc ? '0 : div_q + 1'b1;
    idx_d      = idx_q;
    nib        = '0;
    lz         = '0;
    zero_above = 1'b1;
    if (tc) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    // A digit may blank only if it and every digit above it are zero; digit 0 never blanks.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
      lz[i]      = zero_above && (i != 0);
      if (idx_q == IW'(i)) nib = disp_q[4*i +: 4];
    end
    if (ovf_q)                         seg_d = SEG_DASH;
    else if (blank_lz && lz[idx_q])    seg_d = SEG_BLANK;
    else if (flip_mask[idx_q])         seg_d = seg7_flip(seg7_font(nib));
    else                               seg_d = seg7_font(nib);
    an_d = an_all[DIGITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      div_q  <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign ovf = ovf_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_bcd.sv
// Self-checking bench: an 8-digit and a 4-digit driver checked cycle by cycle against a
// decimal-arithmetic display model, with directed and randomized loads.
module tb_seg7_scan_bcd;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val8 = '0, val4 = '0;
  logic        load8 = 1'b0, load4 = 1'b0, blz = 1'b0;
  logic [7:0]  flip = '0;
  logic        busy8, ovf8, busy4, ovf4;
  logic [6:0]  seg8, seg4;
  logic [7:0]  an8;
  logic [3:0]  an4;

  always #5 clk = ~clk;

  seg7_scan_bcd #(.DIGITS(8), .WIDTH(16), .SCAN_DIV(SD)) dut8 (
    .clk(clk), .rst(rst), .val(val8), .val_load(load8), .blank_lz(blz),
    .flip_mask(flip), .busy(busy8), .ovf(ovf8), .seg(seg8), .an(an8)
  );

  seg7_scan_bcd #(.DIGITS(4), .WIDTH(16), .SCAN_DIV(SD)) dut4 (
    .clk(clk), .rst(rst), .val(val4), .val_load(load4), .blank_lz(blz),
    .flip_mask(flip[3:0]), .busy(busy4), .ovf(ovf4), .seg(seg4), .an(an4)
  );

  int unsigned edgeCnt = 0;
  always @(posedge clk) edgeCnt <= rst ? 0 : edgeCnt + 1;

  int          checkCount = 0, passCount = 0, failCount = 0;
  int unsigned disp8 = 0, disp4 = 0;
  logic [6:0]  fontTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] refSeg(int unsigned v, int nd, int i, bit b, bit f);
    longint unsigned p, lim;
    logic [6:0] s;
    p = 1;
    lim = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    if (v >= lim) return 7'b0111111;
    if (b && i > 0 && v < p) return 7'b1111111;
    s = fontTab[int'((v / p) % 10)];
    if (f) s = {s[6], s[2], s[1], s[0], s[5], s[4], s[3]};
    return s;
  endfunction

  task automatic doCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Walks a full 8-digit refresh, checking both drivers' enable and segment outputs each cycle.
  task automatic checkOutput(input string tag);
    int         d8, d4;
    logic [7:0] e8;
    logic [3:0] e4;
    for (int c = 0; c < 8 * SD; c++) begin
      @(negedge clk);
      d8 = int'(((edgeCnt - 1) / SD) % 8);
      d4 = int'(((edgeCnt - 1) / SD) % 4);
      e8 = 8'hFF;
      e8[d8] = 1'b0;
      e4 = 4'hF;
      e4[d4] = 1'b0;
      doCheck({tag, ".an8"}, an8, e8);
      doCheck({tag, ".seg8"}, seg8, refSeg(disp8, 8, d8, blz, flip[d8]));
      doCheck({tag, ".an4"}, an4, e4);
      doCheck({tag, ".seg4"}, seg4, refSeg(disp4, 4, d4, blz, flip[d4]));
    end
  endtask

  task automatic applyStimulus(input bit sel4, input int unsigned v);
    int n;
    @(negedge clk);
    if (sel4) begin val4 = 16'(v); load4 = 1'b1; end
    else      begin val8 = 16'(v); load8 = 1'b1; end
    @(negedge clk);
    load4 = 1'b0;
    load8 = 1'b0;
    n = 0;
    while ((sel4 ? busy4 : busy8) && n < 100) begin
      n++;
      @(negedge clk);
    end
    doCheck("busyLen", n, 17);
    if (sel4) begin
      disp4 = v;
      doCheck("ovf4", ovf4, (v >= 10000) ? 1 : 0);
    end else begin
      disp8 = v;
      doCheck("ovf8", ovf8, (v >= 100000000) ? 1 : 0);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    int unsigned v;
    bit s4;
    repeat (3) @(negedge clk);
    doCheck("rst.an8", an8, 8'hFF);
    doCheck("rst.seg8", seg8, 7'h7F);
    doCheck("rst.busy8", busy8, 0);
    doCheck("rst.ovf8", ovf8, 0);
    doCheck("rst.an4", an4, 4'hF);
    doCheck("rst.seg4", seg4, 7'h7F);
    rst = 1'b0;
    checkOutput("zero");

    applyStimulus(0, 1234);
    checkOutput("v1234");
    blz = 1'b1;
    @(negedge clk);
    checkOutput("v1234blz");
    applyStimulus(0, 0);
    checkOutput("v0blz");
    blz = 1'b0;
    flip = 8'h01;
    applyStimulus(0, 7);
    checkOutput("v7flip");
    flip = 8'h00;
    applyStimulus(1, 12345);
    checkOutput("ovf12345");
    applyStimulus(1, 9999);
    checkOutput("v9999");

    // Second load while busy must be dropped.
    @(negedge clk);
    val8 = 16'd4321;
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    repeat (3) @(negedge clk);
    val8 = 16'd999;
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    n = 0;
    while (busy8 && n < 100) begin n++; @(negedge clk); end
    doCheck("ignoreBusyEnds", (n < 100) ? 1 : 0, 1);
    disp8 = 4321;
    @(negedge clk);
    doCheck("ignoreBusyIdle", busy8, 0);
    checkOutput("ignore");

    for (int i = 0; i < 8; i++) begin
      s4 = i[0];
      v = s4 ? $urandom_range(0, 19999) : $urandom_range(0, 65535);
      blz = 1'($urandom_range(0, 1));
      flip = 8'($urandom);
      applyStimulus(s4, v);
      checkOutput("rand");
    end

    // Reset in the middle of a conversion discards it.
    blz = 1'b0;
    flip = 8'h00;
    @(negedge clk);
    val8 = 16'd55555;
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    doCheck("rstMid.busy8", busy8, 0);
    doCheck("rstMid.an8", an8, 8'hFF);
    doCheck("rstMid.seg8", seg8, 7'h7F);
    rst = 1'b0;
    disp8 = 0;
    disp4 = 0;
    checkOutput("rstMid");
    doCheck("rstMid.ovf8", ovf8, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
